// File: rtl/mmu_tlb_if.sv
// TLB port bundle between the MMU (master) and the translation cache (slave).
interface mmu_tlb_if #(
  parameter int VPN_W = 27,
  parameter int PPN_W = 44
);
  logic [VPN_W-1:0] tlb_addr;
  logic [PPN_W-1:0] tlb_rdata;
  logic             tlb_hit;
  logic [PPN_W-1:0] tlb_wdata;
  logic             tlb_update;
  logic             flush;
  logic             lookup_valid;
  logic [31:0]      hit_cnt;
  logic [31:0]      miss_cnt;

  modport master (
    output tlb_addr, tlb_wdata, tlb_update, flush, lookup_valid,
    input  tlb_rdata, tlb_hit, hit_cnt, miss_cnt
  );

  modport slave (
    input  tlb_addr, tlb_wdata, tlb_update, flush, lookup_valid,
    output tlb_rdata, tlb_hit, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/mmu_tlb.sv
// Fully-associative TLB with zero-latency lookup, round-robin refill and global flush.
// Optional hit/miss performance counters are built when TLB_PERF_EN is defined.
module mmu_tlb #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 44
) (
  input  logic     clk,
  input  logic     rst_n,
  mmu_tlb_if.slave tlb
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [VPN_W-1:0]   r_tag  [ENTRIES];
  logic [PPN_W-1:0]   r_data [ENTRIES];
  logic [IDX_W-1:0]   r_vptr;

  logic [ENTRIES-1:0] w_match;
  logic               w_any_match;
  logic               w_any_inval;
  logic [IDX_W-1:0]   w_match_idx;
  logic [IDX_W-1:0]   w_inval_idx;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [PPN_W-1:0]   w_rdata;
  logic               w_wr;

  always_comb begin
    w_match     = '0;
    w_rdata     = '0;
    w_match_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_match[i] = r_valid[i] && (r_tag[i] == tlb.tlb_addr);
      if (w_match[i]) begin
        w_rdata     = w_rdata | r_data[i];
        w_match_idx = IDX_W'(i);
      end
    end
  end

  // Descending scan so the lowest-index free slot wins.
  always_comb begin
    w_inval_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_inval_idx = IDX_W'(i);
    end
  end

  assign w_any_match = |w_match;
  assign w_any_inval = ~&r_valid;
  assign w_wr        = tlb.tlb_update && !tlb.flush;
  assign w_wr_idx    = w_any_match ? w_match_idx :
                       w_any_inval ? w_inval_idx : r_vptr;

  assign tlb.tlb_hit   = w_any_match && !tlb.flush;
  assign tlb.tlb_rdata = tlb.flush ? '0 : w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_vptr  <= '0;
    end else if (tlb.flush) begin
      r_valid <= '0;
      r_vptr  <= '0;
    end else if (w_wr) begin
      r_valid[w_wr_idx] <= 1'b1;
      if (!w_any_match && !w_any_inval) r_vptr <= r_vptr + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_tag[w_wr_idx]  <= tlb.tlb_addr;
      r_data[w_wr_idx] <= tlb.tlb_wdata;
    end
  end

`ifdef TLB_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (tlb.lookup_valid && !tlb.flush) begin
      if (w_any_match) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign tlb.hit_cnt  = r_hit_cnt;
  assign tlb.miss_cnt = r_miss_cnt;
`else
  logic w_unused_lookup;
  assign w_unused_lookup = tlb.lookup_valid;
  assign tlb.hit_cnt     = 32'h0;
  assign tlb.miss_cnt    = 32'h0;
`endif
endmodule
